// File: rtl/pmod_7led_pkg.sv
// Shared types and constants for the serial shift/latch receiver: row geometry,
// receive FSM states and row-select decode helpers.
package pmod_7led_pkg;

    localparam int ROWS          = 8;
    localparam int COLS          = 8;
    localparam int WIDTH_DEFAULT = 16;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SHIFTING = 2'd1,
        ST_OVERRUN  = 2'd2
    } rx_state_e;

    function automatic logic row_onehot(input logic [ROWS-1:0] r);
        return $onehot(r);
    endfunction

    // Index of the single set bit; 0 whenever the field is not one-hot.
    function automatic logic [2:0] row_index(input logic [ROWS-1:0] r);
        logic [2:0] idx;
        idx = '0;
        if ($onehot(r)) begin
            for (int i = 0; i < ROWS; i++) begin
                if (r[i]) idx = 3'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/shift_latch_receiver_sync_edge.sv
// Multi-flop synchronizer for one asynchronous input; optionally reports a
// single-cycle pulse on each synchronized 0->1 transition instead of the level.
module sync_edge #(
    parameter int SYNC_STAGES = 2,
    parameter bit EDGE_DET    = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
        end
    end

    generate
        if (EDGE_DET) begin : g_edge
            logic                 prev_q;
            logic [SYNC_STAGES:0] armed_q;

            // A line already high at reset release ripples through the
            // zeroed chain as a 0->1 step; armed_q hides that first step.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    prev_q  <= 1'b0;
                    armed_q <= '0;
                end else begin
                    prev_q  <= sync_q[SYNC_STAGES-1];
                    armed_q <= {armed_q[SYNC_STAGES-1:0], 1'b1};
                end
            end

            assign q_o = sync_q[SYNC_STAGES-1] & ~prev_q & armed_q[SYNC_STAGES];
        end else begin : g_level
            assign q_o = sync_q[SYNC_STAGES-1];
        end
    endgenerate

endmodule

// File: rtl/shift_latch_receiver.sv
// 74HC595-style serial receiver sampled on the system clock: shift register,
// storage latch, row/column decode, per-row storage and frame completion.
module shift_latch_receiver
    import pmod_7led_pkg::*;
#(
    parameter int WIDTH       = WIDTH_DEFAULT,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sclk_in,
    input  logic             rclk_in,
    input  logic             srclr_n_in,
    input  logic             serial_in,
    output logic [WIDTH-1:0] q,
    output logic             line_valid,
    output logic [2:0]       row_idx,
    output logic [COLS-1:0]  col_bits,
    output logic             row_err,
    output logic             len_err,
    output logic             frame_done,
    input  logic [2:0]       rd_row,
    output logic [COLS-1:0]  rd_data
);

    localparam int               CNT_W   = $clog2(WIDTH + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam int               ROW_LSB  = COLS;
    localparam int               ROW_MSB  = COLS + ROWS - 1;

    logic sclk_rise;
    logic rclk_rise;
    logic srclr_sync;
    logic serial_sync;
    logic shift_en;

    sync_edge #(.SYNC_STAGES(SYNC_STAGES), .EDGE_DET(1'b1)) u_sclk_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (sclk_in),
        .q_o   (sclk_rise)
    );

    sync_edge #(.SYNC_STAGES(SYNC_STAGES), .EDGE_DET(1'b1)) u_rclk_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (rclk_in),
        .q_o   (rclk_rise)
    );

    sync_edge #(.SYNC_STAGES(SYNC_STAGES), .EDGE_DET(1'b0)) u_srclr_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (srclr_n_in),
        .q_o   (srclr_sync)
    );

    sync_edge #(.SYNC_STAGES(SYNC_STAGES), .EDGE_DET(1'b0)) u_serial_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (serial_in),
        .q_o   (serial_sync)
    );

    rx_state_e                   state_q, state_d;
    logic [WIDTH-1:0]            sr_q, sr_d;
    logic [WIDTH-1:0]            q_q, q_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [ROWS-1:0][COLS-1:0]   rows_q, rows_d;
    logic [ROWS-1:0]             mask_q, mask_d;
    logic                        line_valid_q, line_valid_d;
    logic                        row_err_q, row_err_d;
    logic                        len_err_q, len_err_d;
    logic                        frame_done_q, frame_done_d;
    logic [ROWS-1:0]             sr_row;
    logic [2:0]                  latch_idx;

    assign shift_en  = sclk_rise & srclr_sync;
    assign sr_row    = sr_q[ROW_MSB:ROW_LSB];
    assign latch_idx = row_index(sr_row);

    always_comb begin
        state_d = state_q;
        if (!srclr_sync) begin
            state_d = ST_IDLE;
        end else if (rclk_rise) begin
            state_d = shift_en ? ST_SHIFTING : ST_IDLE;
        end else if (shift_en) begin
            case (state_q)
                ST_IDLE:     state_d = ST_SHIFTING;
                ST_SHIFTING: if (cnt_q == CNT_FULL) state_d = ST_OVERRUN;
                default:     state_d = ST_OVERRUN;
            endcase
        end
    end

    always_comb begin
        sr_d         = sr_q;
        q_d          = q_q;
        cnt_d        = cnt_q;
        rows_d       = rows_q;
        mask_d       = mask_q;
        line_valid_d = rclk_rise;
        row_err_d    = 1'b0;
        len_err_d    = 1'b0;
        frame_done_d = (mask_q == '1);

        if (frame_done_d) mask_d = '0;

        if (!srclr_sync) begin
            sr_d  = '0;
            cnt_d = '0;
        end else begin
            if (shift_en) sr_d = {serial_sync, sr_q[WIDTH-1:1]};
            if (rclk_rise) begin
                cnt_d = shift_en ? CNT_ONE : '0;
            end else if (shift_en && state_q != ST_OVERRUN) begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end

        // The latch takes the pre-shift word, so tied clocks behave like a 595.
        if (rclk_rise) begin
            q_d       = sr_q;
            len_err_d = (cnt_q != CNT_FULL);
            if (row_onehot(sr_row)) begin
                rows_d[latch_idx] = sr_q[COLS-1:0];
                mask_d[latch_idx] = 1'b1;
            end else begin
                row_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            sr_q         <= '0;
            q_q          <= '0;
            cnt_q        <= '0;
            rows_q       <= '0;
            mask_q       <= '0;
            line_valid_q <= 1'b0;
            row_err_q    <= 1'b0;
            len_err_q    <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            sr_q         <= sr_d;
            q_q          <= q_d;
            cnt_q        <= cnt_d;
            rows_q       <= rows_d;
            mask_q       <= mask_d;
            line_valid_q <= line_valid_d;
            row_err_q    <= row_err_d;
            len_err_q    <= len_err_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign q          = q_q;
    assign line_valid = line_valid_q;
    assign row_idx    = row_index(q_q[ROW_MSB:ROW_LSB]);
    assign col_bits   = q_q[COLS-1:0];
    assign row_err    = row_err_q;
    assign len_err    = len_err_q;
    assign frame_done = frame_done_q;
    assign rd_data    = rows_q[rd_row];

endmodule
